mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single memory controller port between two requesters: the CPU control unit ("core") and a debug/program-loader port ("dbg").
- Sits between `ctrl` and the memory controller.
  - Presents `mem_ctrl_op` / `mem_op_done` style handshakes upstream to each requester.
  - Drives one latched request downstream.
- Provides round-robin or debug-priority arbitration and a per-transaction timeout watchdog.

Parameters:
- DATA_BUS_WIDTH, 8, data width of read/write data.
- ADDR_WIDTH, 16, memory address width.
- DBG_PRIORITY, 0, 0 = round-robin; 1 = dbg always wins simultaneous requests.
- TIMEOUT_CYCLES, 255, downstream cycles allowed before abort; 0 disables the watchdog.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- core_op  in  mem_ctrl_op_e  core request; held until core_done.
- core_addr  in  ADDR_WIDTH  core address.
- core_wdata  in  DATA_BUS_WIDTH  core write data.
- core_rdata  out  DATA_BUS_WIDTH  core read data, valid from core_done.
- core_done  out  1  one-cycle completion pulse to core.
- dbg_op  in  mem_ctrl_op_e  debug request; held until dbg_done.
- dbg_addr  in  ADDR_WIDTH  debug address.
- dbg_wdata  in  DATA_BUS_WIDTH  debug write data.
- dbg_rdata  out  DATA_BUS_WIDTH  debug read data.
- dbg_done  out  1  one-cycle completion pulse to debug.
- mem_op  out  mem_ctrl_op_e  downstream operation.
- mem_addr  out  ADDR_WIDTH  downstream address.
- mem_wdata  out  DATA_BUS_WIDTH  downstream write data.
- mem_rdata  in  DATA_BUS_WIDTH  downstream read data, valid with mem_op_done.
- mem_op_done  in  1  downstream completion pulse.
- grant_dbg  out  1  1 while a dbg transaction owns the port.
- timeout_err  out  1  sticky; set on watchdog abort, cleared by reset.

Behaviour:
- Reset values:
  - state IDLE; mem_op = MEM_CTRL_NOP.
  - mem_addr, mem_wdata, core_rdata, dbg_rdata = 0.
  - core_done, dbg_done, grant_dbg, timeout_err = 0.
  - last_grant = dbg, so the first round-robin tie goes to core.
- A request is pending when the requester's op != MEM_CTRL_NOP.
- IDLE:
  - Neither pending: stay in IDLE.
  - One pending: grant it.
  - Both pending: DBG_PRIORITY=1 grants dbg; otherwise grant the side opposite last_grant.
  - On grant: latch op/addr/wdata into mem_op/mem_addr/mem_wdata, update last_grant, go to BUSY_CORE or BUSY_DBG.
  - mem_op is valid in the cycle after the request is sampled (1-cycle grant latency).
- BUSY_x:
  - Downstream outputs are held constant; requester input changes are ignored.
  - On mem_op_done, at the next edge:
    - mem_op = NOP.
    - If the op was a read, x_rdata = mem_rdata (writes leave x_rdata unchanged).
    - x_done = 1 for exactly one cycle.
    - Go to DONE.
- DONE:
  - One mandatory idle cycle so the requester can drop or replace its op; no arbitration here.
  - Then return to IDLE.
  - Back-to-back requests from one requester therefore see 3 cycles overhead plus downstream latency.
- Watchdog:
  - Counter clears on grant and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES with no mem_op_done: mem_op = NOP, x_done pulses, x_rdata = all-ones, timeout_err = 1, go to DONE.
  - If mem_op_done arrives in the same cycle as the limit, the done wins and no error is flagged.
- mem_op_done in IDLE or DONE is ignored.
- Reset asserted mid-transaction: all outputs return to reset values at that edge; the downstream controller shares the same reset.
- core_done and dbg_done are never high in the same cycle.
- grant_dbg = 1 exactly in BUSY_DBG.

Decomposition:
- The shared CPU package already holds mem_ctrl_op_e (MEM_CTRL_NOP, MEM_CTRL_READ, MEM_CTRL_WRITE).
- Add arb_state_e (ARB_IDLE, ARB_BUSY_CORE, ARB_BUSY_DBG, ARB_DONE) to the same package.
- Sub-module arb_watchdog: loadable down-counter with enable, clear and expired output, parameterised by TIMEOUT_CYCLES.
- Arbitration and latching stay in mem_arbiter.

Test Plan:
- Core read 0x0123, dbg idle, mem_op_done 4 cycles after mem_op=READ with mem_rdata=0xA5 -> mem_op READ one cycle after request; core_done single pulse; core_rdata=0xA5; grant_dbg stays 0.
- Core write 0x0010 and dbg write 0x0020 raised in the same cycle, DBG_PRIORITY=0, right after reset -> core served first; dbg granted on the next IDLE, mem_addr=0x0020; one done pulse per side, never overlapping.
- Same as above with DBG_PRIORITY=1, core re-requesting continuously -> dbg served first; core served next; no starvation of core once dbg drops its op.
- TIMEOUT_CYCLES=8, mem_op_done never asserted on a dbg read -> after 8 busy cycles mem_op NOP, dbg_done pulse, dbg_rdata=0xFF, timeout_err=1 until reset.
- Reset asserted 2 cycles into a core write -> next cycle mem_op NOP, state IDLE, no core_done; a late mem_op_done is ignored.
- Requester changes core_addr 0x0001→0x0002 while BUSY_CORE -> mem_addr stays 0x0001 until completion.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: controller op codes, arbiter states
// and a small request-decode helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        MEM_CTRL_NOP   = 2'd0,
        MEM_CTRL_READ  = 2'd1,
        MEM_CTRL_WRITE = 2'd2
    } mem_ctrl_op_e;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_BUSY_CORE = 2'd1,
        ARB_BUSY_DBG  = 2'd2,
        ARB_DONE      = 2'd3
    } arb_state_e;

    function automatic logic is_pending(mem_ctrl_op_e op);
        return op != MEM_CTRL_NOP;
    endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Per-transaction watchdog: reloads on clear, counts down while enabled and
// flags expiry on the last allowed busy cycle. A limit of 0 disables it.
module arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LOAD_VALUE = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= LOAD_VALUE;
        end else if (enable && count != '0) begin
            count <= count - 1'b1;
        end
    end

    // count == 1 means this busy cycle is the last one allowed
    assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == CW'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (core, dbg) in front of a single memory controller port,
// with round-robin or debug-priority selection and a transaction watchdog.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int DBG_PRIORITY   = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  mem_ctrl_op_e              core_op,
    input  logic [ADDR_WIDTH-1:0]     core_addr,
    input  logic [DATA_BUS_WIDTH-1:0] core_wdata,
    output logic [DATA_BUS_WIDTH-1:0] core_rdata,
    output logic                      core_done,
    input  mem_ctrl_op_e              dbg_op,
    input  logic [ADDR_WIDTH-1:0]     dbg_addr,
    input  logic [DATA_BUS_WIDTH-1:0] dbg_wdata,
    output logic [DATA_BUS_WIDTH-1:0] dbg_rdata,
    output logic                      dbg_done,
    output mem_ctrl_op_e              mem_op,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_BUS_WIDTH-1:0] mem_wdata,
    input  logic [DATA_BUS_WIDTH-1:0] mem_rdata,
    input  logic                      mem_op_done,
    output logic                      grant_dbg,
    output logic                      timeout_err
);

    arb_state_e state;
    logic       last_grant_dbg;
    logic       core_pend;
    logic       dbg_pend;
    logic       pick_dbg;
    logic       busy;
    logic       wd_expired;
    logic       finish;

    assign core_pend = is_pending(core_op);
    assign dbg_pend  = is_pending(dbg_op);
    assign pick_dbg  = dbg_pend && (!core_pend || DBG_PRIORITY != 0 || !last_grant_dbg);
    assign busy      = (state == ARB_BUSY_CORE) || (state == ARB_BUSY_DBG);
    // A completion arriving on the limit cycle takes precedence over the abort
    assign finish    = mem_op_done || wd_expired;

    arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  ((state == ARB_IDLE) && (core_pend || dbg_pend)),
        .enable (busy),
        .expired(wd_expired)
    );

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // branch reads the pre-edge values of state, mem_op and the counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ARB_IDLE;
            mem_op         <= MEM_CTRL_NOP;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            core_rdata     <= '0;
            dbg_rdata      <= '0;
            core_done      <= 1'b0;
            dbg_done       <= 1'b0;
            grant_dbg      <= 1'b0;
            timeout_err    <= 1'b0;
            last_grant_dbg <= 1'b1;
        end else begin
            core_done <= 1'b0;
            dbg_done  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (pick_dbg) begin
                        state          <= ARB_BUSY_DBG;
                        mem_op         <= dbg_op;
                        mem_addr       <= dbg_addr;
                        mem_wdata      <= dbg_wdata;
                        last_grant_dbg <= 1'b1;
                        grant_dbg      <= 1'b1;
                    end else if (core_pend) begin
                        state          <= ARB_BUSY_CORE;
                        mem_op         <= core_op;
                        mem_addr       <= core_addr;
                        mem_wdata      <= core_wdata;
                        last_grant_dbg <= 1'b0;
                    end
                end
                ARB_BUSY_CORE, ARB_BUSY_DBG: begin
                    if (finish) begin
                        state     <= ARB_DONE;
                        mem_op    <= MEM_CTRL_NOP;
                        grant_dbg <= 1'b0;
                        if (!mem_op_done) begin
                            timeout_err <= 1'b1;
                        end
                        if (state == ARB_BUSY_DBG) begin
                            dbg_done <= 1'b1;
                            if (!mem_op_done) begin
                                dbg_rdata <= '1;
                            end else if (mem_op == MEM_CTRL_READ) begin
                                dbg_rdata <= mem_rdata;
                            end
                        end else begin
                            core_done <= 1'b1;
                            if (!mem_op_done) begin
                                core_rdata <= '1;
                            end else if (mem_op == MEM_CTRL_READ) begin
                                core_rdata <= mem_rdata;
                            end
                        end
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, cycle-exact bench for mem_arbiter: a round-robin instance and a
// debug-priority instance, both with an 8-cycle watchdog.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam mem_ctrl_op_e N = MEM_CTRL_NOP;
    localparam mem_ctrl_op_e R = MEM_CTRL_READ;
    localparam mem_ctrl_op_e W = MEM_CTRL_WRITE;

    typedef struct {
        logic         rst;
        mem_ctrl_op_e cop;
        logic [15:0]  caddr;
        logic [7:0]   cwd;
        mem_ctrl_op_e dop;
        logic [15:0]  daddr;
        logic [7:0]   dwd;
        logic         done;
        logic [7:0]   rdata;
        mem_ctrl_op_e e_op;
        logic [15:0]  e_addr;
        logic [7:0]   e_wd;
        logic         e_cdone;
        logic         e_ddone;
        logic [7:0]   e_crd;
        logic [7:0]   e_drd;
        logic         e_gnt;
        logic         e_terr;
    } vec_t;

    logic         clock = 1'b0;
    logic         reset;
    mem_ctrl_op_e core_op, dbg_op;
    logic [15:0]  core_addr, dbg_addr;
    logic [7:0]   core_wdata, dbg_wdata, mem_rdata;
    logic         done_rr, done_pri;

    logic [7:0]   rr_core_rdata, rr_dbg_rdata, rr_mem_wdata;
    logic         rr_core_done, rr_dbg_done, rr_grant_dbg, rr_timeout_err;
    mem_ctrl_op_e rr_mem_op;
    logic [15:0]  rr_mem_addr;
    logic [7:0]   pri_core_rdata, pri_dbg_rdata, pri_mem_wdata;
    logic         pri_core_done, pri_dbg_done, pri_grant_dbg, pri_timeout_err;
    mem_ctrl_op_e pri_mem_op;
    logic [15:0]  pri_mem_addr;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tbl[$];

    always #5 clock = ~clock;

    mem_arbiter #(.DATA_BUS_WIDTH(8), .ADDR_WIDTH(16), .DBG_PRIORITY(0), .TIMEOUT_CYCLES(8)) dut_rr (
        .clock(clock), .reset(reset),
        .core_op(core_op), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(rr_core_rdata), .core_done(rr_core_done),
        .dbg_op(dbg_op), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(rr_dbg_rdata), .dbg_done(rr_dbg_done),
        .mem_op(rr_mem_op), .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata),
        .mem_rdata(mem_rdata), .mem_op_done(done_rr),
        .grant_dbg(rr_grant_dbg), .timeout_err(rr_timeout_err)
    );

    mem_arbiter #(.DATA_BUS_WIDTH(8), .ADDR_WIDTH(16), .DBG_PRIORITY(1), .TIMEOUT_CYCLES(8)) dut_pri (
        .clock(clock), .reset(reset),
        .core_op(core_op), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(pri_core_rdata), .core_done(pri_core_done),
        .dbg_op(dbg_op), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(pri_dbg_rdata), .dbg_done(pri_dbg_done),
        .mem_op(pri_mem_op), .mem_addr(pri_mem_addr), .mem_wdata(pri_mem_wdata),
        .mem_rdata(mem_rdata), .mem_op_done(done_pri),
        .grant_dbg(pri_grant_dbg), .timeout_err(pri_timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic rst,
                               input mem_ctrl_op_e cop, input logic [15:0] ca, input logic [7:0] cw,
                               input mem_ctrl_op_e dop, input logic [15:0] da, input logic [7:0] dw,
                               input logic dn, input logic [7:0] rd,
                               input mem_ctrl_op_e eop, input logic [15:0] ea, input logic [7:0] ew,
                               input logic ecd, input logic edd, input logic [7:0] ecr,
                               input logic [7:0] edr, input logic eg, input logic et);
        vec_t r;
        r.rst = rst; r.cop = cop; r.caddr = ca; r.cwd = cw;
        r.dop = dop; r.daddr = da; r.dwd = dw; r.done = dn; r.rdata = rd;
        r.e_op = eop; r.e_addr = ea; r.e_wd = ew; r.e_cdone = ecd; r.e_ddone = edd;
        r.e_crd = ecr; r.e_drd = edr; r.e_gnt = eg; r.e_terr = et;
        return r;
    endfunction

    function automatic vec_t rst_vec();
        return v(1, N, 0, 0, N, 0, 0, 0, 0, N, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Drive one cycle of inputs, then check the selected instance just after the edge
    task automatic run_vec(input vec_t t, input bit pri, input string tag, input int idx);
        mem_ctrl_op_e a_op;
        logic [15:0]  a_addr;
        logic [7:0]   a_wd, a_crd, a_drd;
        logic         a_cd, a_dd, a_g, a_te;
        reset      = t.rst;
        core_op    = t.cop;  core_addr = t.caddr; core_wdata = t.cwd;
        dbg_op     = t.dop;  dbg_addr  = t.daddr; dbg_wdata  = t.dwd;
        mem_rdata  = t.rdata;
        done_rr    = pri ? 1'b0 : t.done;
        done_pri   = pri ? t.done : 1'b0;
        @(posedge clock);
        #1;
        if (pri) begin
            a_op = pri_mem_op; a_addr = pri_mem_addr; a_wd = pri_mem_wdata;
            a_cd = pri_core_done; a_dd = pri_dbg_done; a_crd = pri_core_rdata;
            a_drd = pri_dbg_rdata; a_g = pri_grant_dbg; a_te = pri_timeout_err;
        end else begin
            a_op = rr_mem_op; a_addr = rr_mem_addr; a_wd = rr_mem_wdata;
            a_cd = rr_core_done; a_dd = rr_dbg_done; a_crd = rr_core_rdata;
            a_drd = rr_dbg_rdata; a_g = rr_grant_dbg; a_te = rr_timeout_err;
        end
        check($sformatf("%s[%0d].mem_op", tag, idx),      32'(a_op),   32'(t.e_op));
        check($sformatf("%s[%0d].mem_addr", tag, idx),    32'(a_addr), 32'(t.e_addr));
        check($sformatf("%s[%0d].mem_wdata", tag, idx),   32'(a_wd),   32'(t.e_wd));
        check($sformatf("%s[%0d].core_done", tag, idx),   32'(a_cd),   32'(t.e_cdone));
        check($sformatf("%s[%0d].dbg_done", tag, idx),    32'(a_dd),   32'(t.e_ddone));
        check($sformatf("%s[%0d].core_rdata", tag, idx),  32'(a_crd),  32'(t.e_crd));
        check($sformatf("%s[%0d].dbg_rdata", tag, idx),   32'(a_drd),  32'(t.e_drd));
        check($sformatf("%s[%0d].grant_dbg", tag, idx),   32'(a_g),    32'(t.e_gnt));
        check($sformatf("%s[%0d].timeout_err", tag, idx), 32'(a_te),   32'(t.e_terr));
    endtask

    initial begin
        // Core read 0x0123, done in the 4th busy cycle with 0xA5
        tbl.push_back(rst_vec());
        tbl.push_back(v(0, R, 16'h0123, 0, N, 0, 0, 0, 0,    R, 16'h0123, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0, R, 16'h0123, 0, N, 0, 0, 0, 0, R, 16'h0123, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, R, 16'h0123, 0, N, 0, 0, 1, 8'hA5, N, 16'h0123, 0, 1, 0, 8'hA5, 0, 0, 0));
        tbl.push_back(v(0, N, 0, 0, N, 0, 0, 0, 0,          N, 16'h0123, 0, 0, 0, 8'hA5, 0, 0, 0));

        // Simultaneous writes right after reset: core first, dbg on next IDLE
        tbl.push_back(rst_vec());
        tbl.push_back(v(0, W, 16'h0010, 8'h11, W, 16'h0020, 8'h22, 0, 0,    W, 16'h0010, 8'h11, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, W, 16'h0010, 8'h11, W, 16'h0020, 8'h22, 1, 0,    N, 16'h0010, 8'h11, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, N, 16'h0010, 8'h11, W, 16'h0020, 8'h22, 0, 0,    N, 16'h0010, 8'h11, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, N, 0, 0, W, 16'h0020, 8'h22, 0, 0,              W, 16'h0020, 8'h22, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, N, 0, 0, W, 16'h0020, 8'h22, 1, 8'h77,          N, 16'h0020, 8'h22, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, N, 0, 0, N, 0, 0, 0, 0,                         N, 16'h0020, 8'h22, 0, 0, 0, 0, 0, 0));

        // Core address/op changes while busy are ignored, then a round-robin tie
        tbl.push_back(rst_vec());
        tbl.push_back(v(0, R, 16'h0001, 0, N, 0, 0, 0, 0,        R, 16'h0001, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, R, 16'h0002, 0, N, 0, 0, 0, 0,        R, 16'h0001, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, W, 16'h0002, 8'h55, N, 0, 0, 0, 0,    R, 16'h0001, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, R, 16'h0002, 0, N, 0, 0, 1, 8'h3C,    N, 16'h0001, 0, 1, 0, 8'h3C, 0, 0, 0));
        tbl.push_back(v(0, N, 0, 0, N, 0, 0, 0, 0,              N, 16'h0001, 0, 0, 0, 8'h3C, 0, 0, 0));
        tbl.push_back(v(0, R, 16'h0100, 0, R, 16'h0200, 0, 0, 0,       R, 16'h0200, 0, 0, 0, 8'h3C, 0, 1, 0));
        tbl.push_back(v(0, R, 16'h0100, 0, R, 16'h0200, 0, 1, 8'h5A,   N, 16'h0200, 0, 0, 1, 8'h3C, 8'h5A, 0, 0));
        tbl.push_back(v(0, R, 16'h0100, 0, N, 0, 0, 0, 0,              N, 16'h0200, 0, 0, 0, 8'h3C, 8'h5A, 0, 0));
        tbl.push_back(v(0, R, 16'h0100, 0, N, 0, 0, 0, 0,              R, 16'h0100, 0, 0, 0, 8'h3C, 8'h5A, 0, 0));
        tbl.push_back(v(0, R, 16'h0100, 0, N, 0, 0, 1, 8'h66,          N, 16'h0100, 0, 1, 0, 8'h66, 8'h5A, 0, 0));
        tbl.push_back(v(0, N, 0, 0, N, 0, 0, 0, 0,                     N, 16'h0100, 0, 0, 0, 8'h66, 8'h5A, 0, 0));
        tbl.push_back(v(0, N, 0, 0, N, 0, 0, 1, 8'h99,                 N, 16'h0100, 0, 0, 0, 8'h66, 8'h5A, 0, 0));

        // Watchdog abort of a dbg read after 8 busy cycles; error stays sticky
        tbl.push_back(rst_vec());
        tbl.push_back(v(0, N, 0, 0, R, 16'h0AAA, 0, 0, 0,     R, 16'h0AAA, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 7; i++)
            tbl.push_back(v(0, N, 0, 0, R, 16'h0AAA, 0, 0, 0, R, 16'h0AAA, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, N, 0, 0, R, 16'h0AAA, 0, 0, 0,     N, 16'h0AAA, 0, 0, 1, 0, 8'hFF, 0, 1));
        tbl.push_back(v(0, N, 0, 0, N, 0, 0, 0, 0,            N, 16'h0AAA, 0, 0, 0, 0, 8'hFF, 0, 1));
        tbl.push_back(v(0, N, 0, 0, N, 0, 0, 1, 8'h12,        N, 16'h0AAA, 0, 0, 0, 0, 8'hFF, 0, 1));

        // Reset two cycles into a core write; late mem_op_done is ignored
        tbl.push_back(rst_vec());
        tbl.push_back(v(0, W, 16'h0040, 8'h3C, N, 0, 0, 0, 0,  W, 16'h0040, 8'h3C, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, W, 16'h0040, 8'h3C, N, 0, 0, 0, 0,  W, 16'h0040, 8'h3C, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, W, 16'h0040, 8'h3C, N, 0, 0, 0, 0,  W, 16'h0040, 8'h3C, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, W, 16'h0040, 8'h3C, N, 0, 0, 0, 0,  N, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, N, 0, 0, N, 0, 0, 1, 8'h44,         N, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, N, 0, 0, N, 0, 0, 0, 0,             N, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++)
            run_vec(tbl[i], 1'b0, "tbl", i);

        // Completion on the watchdog limit cycle wins: no error, real read data
        run_vec(rst_vec(), 1'b0, "lim", 0);
        run_vec(v(0, R, 16'h0077, 0, N, 0, 0, 0, 0, R, 16'h0077, 0, 0, 0, 0, 0, 0, 0), 1'b0, "lim", 1);
        for (int i = 0; i < 7; i++)
            run_vec(v(0, R, 16'h0077, 0, N, 0, 0, 0, 0, R, 16'h0077, 0, 0, 0, 0, 0, 0, 0), 1'b0, "lim", 2 + i);
        run_vec(v(0, R, 16'h0077, 0, N, 0, 0, 1, 8'hC3, N, 16'h0077, 0, 1, 0, 8'hC3, 0, 0, 0), 1'b0, "lim", 9);
        run_vec(v(0, N, 0, 0, N, 0, 0, 0, 0, N, 16'h0077, 0, 0, 0, 8'hC3, 0, 0, 0), 1'b0, "lim", 10);

        // Debug priority: dbg wins ties, core served once dbg drops its op
        run_vec(rst_vec(), 1'b1, "pri", 0);
        run_vec(v(0, W, 16'h0010, 8'h11, W, 16'h0020, 8'h22, 0, 0, W, 16'h0020, 8'h22, 0, 0, 0, 0, 1, 0), 1'b1, "pri", 1);
        run_vec(v(0, W, 16'h0010, 8'h11, W, 16'h0020, 8'h22, 1, 0, N, 16'h0020, 8'h22, 0, 1, 0, 0, 0, 0), 1'b1, "pri", 2);
        run_vec(v(0, W, 16'h0010, 8'h11, N, 0, 0, 0, 0,            N, 16'h0020, 8'h22, 0, 0, 0, 0, 0, 0), 1'b1, "pri", 3);
        run_vec(v(0, W, 16'h0010, 8'h11, N, 0, 0, 0, 0,            W, 16'h0010, 8'h11, 0, 0, 0, 0, 0, 0), 1'b1, "pri", 4);
        run_vec(v(0, W, 16'h0010, 8'h11, W, 16'h0030, 8'h33, 1, 0, N, 16'h0010, 8'h11, 1, 0, 0, 0, 0, 0), 1'b1, "pri", 5);
        run_vec(v(0, W, 16'h0010, 8'h11, W, 16'h0030, 8'h33, 0, 0, N, 16'h0010, 8'h11, 0, 0, 0, 0, 0, 0), 1'b1, "pri", 6);
        run_vec(v(0, W, 16'h0010, 8'h11, W, 16'h0030, 8'h33, 0, 0, W, 16'h0030, 8'h33, 0, 0, 0, 0, 1, 0), 1'b1, "pri", 7);
        run_vec(v(0, W, 16'h0010, 8'h11, W, 16'h0030, 8'h33, 1, 0, N, 16'h0030, 8'h33, 0, 1, 0, 0, 0, 0), 1'b1, "pri", 8);
        run_vec(v(0, W, 16'h0010, 8'h11, N, 0, 0, 0, 0,            N, 16'h0030, 8'h33, 0, 0, 0, 0, 0, 0), 1'b1, "pri", 9);
        run_vec(v(0, W, 16'h0010, 8'h11, N, 0, 0, 0, 0,            W, 16'h0010, 8'h11, 0, 0, 0, 0, 0, 0), 1'b1, "pri", 10);
        run_vec(v(0, W, 16'h0010, 8'h11, N, 0, 0, 1, 0,            N, 16'h0010, 8'h11, 1, 0, 0, 0, 0, 0), 1'b1, "pri", 11);
        run_vec(v(0, N, 0, 0, N, 0, 0, 0, 0,                       N, 16'h0010, 8'h11, 0, 0, 0, 0, 0, 0), 1'b1, "pri", 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
